link_parameter_loader: RTL and testbench

Upstream stage of the neighbour-link array. Accepts a stream of per-link parameter words (weight, boundary condition) over a valid/ready handshake and assembles one complete frame of NUM_LINKS entries. It then presents the frame, all entries changing in the same cycle, on the weight_in/boundary_condition_in inputs of every link. Links sample these every cycle while global_stage == STAGE_PARAMETERS_LOADING, so outputs must be stable and complete for that whole stage.

---
 rtl/helios_link_pkg.sv | 33 +++
 rtl/parameters.sv | 18 +
 rtl/link_parameter_loader.sv | 167 ++++++++++++++++
 tb/tb_link_parameter_loader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/helios_link_pkg.sv
// Shared types and helpers for the neighbour-link array.
//   link_bit_width() : bits needed to hold a link weight 0..max_weight
//   boundary_code_t  : per-link boundary condition encoding
//   loader_state_t   : parameter loader FSM states
//   PARITY_BITS      : 1 when LOADER_PARITY_EN is defined (parameter words
//                      carry an extra even-parity MSB), otherwise 0
package helios_link_pkg;

  function automatic int link_bit_width(input int max_weight);
    // A weight range of 0..0 still needs one wire.
    return (max_weight < 1) ? 1 : $clog2(max_weight + 1);
  endfunction

  typedef enum logic [1:0] {
    BC_NONE     = 2'd0,
    BC_BOUNDARY = 2'd1,
    BC_ABSENT   = 2'd2,
    BC_FIFO     = 2'd3
  } boundary_code_t;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_FILL = 2'd1,
    LD_FULL = 2'd2
  } loader_state_t;

`ifdef LOADER_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

endpackage

// File: rtl/parameters.sv
// Global decoder stage codes shared by every block that follows the decoder
// sequencing. The link parameter loader only looks for
// STAGE_PARAMETERS_LOADING; the other codes are listed so the encoding is
// documented in one place.
package decoder_stage_pkg;

  localparam int STAGE_WIDTH = 3;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                  = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_PREPARING = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING   = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                  = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE                 = 3'd4;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING               = 3'd5;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID          = 3'd6;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING    = 3'd7;

endpackage

// File: rtl/link_parameter_loader.sv
// link_parameter_loader
//   Collects NUM_LINKS parameter words (weight, boundary code) from a
//   valid/ready stream into a staging frame, then commits the whole frame at
//   once onto registered per-link buses. The committed frame is held until the
//   next commit, so links sampling during STAGE_PARAMETERS_LOADING always see
//   a complete, stable frame.
//
// Optional build macro: LOADER_PARITY_EN
//   Adds an even-parity MSB to param_data and a sticky parity_error output.
//   Bad-parity words are handshaken but dropped.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   global_stage      decoder stage code
//   param_valid/ready word handshake (ready is combinational)
//   param_data        {[parity,] weight[IN_WEIGHT_WIDTH-1:0], boundary[1:0]}
//   param_clear       abort current assembly; wins over a same-cycle word
//   weight_bus        link k weight at slice k (LINK_BIT_WIDTH each)
//   boundary_bus      link k boundary code at slice k (2 bits each)
//   frame_loaded      a frame was committed since the last clear
//   load_count        words accepted into the current frame
//   weight_clamped    sticky: an incoming weight exceeded MAX_WEIGHT
//   frame_incomplete  sticky: parameter-loading stage seen with no frame
//   parity_error      sticky: bad-parity word seen (LOADER_PARITY_EN only)
module link_parameter_loader
  import helios_link_pkg::*;
  import decoder_stage_pkg::*;
#(
  parameter int NUM_LINKS       = 16,
  parameter int MAX_WEIGHT      = 2,
  parameter int IN_WEIGHT_WIDTH = 4,
  localparam int LINK_BIT_WIDTH = link_bit_width(MAX_WEIGHT),
  localparam int COUNT_WIDTH    = $clog2(NUM_LINKS + 1),
  localparam int DATA_WIDTH     = IN_WEIGHT_WIDTH + 2 + PARITY_BITS
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [STAGE_WIDTH-1:0]              global_stage,
  input  logic                                param_valid,
  output logic                                param_ready,
  input  logic [DATA_WIDTH-1:0]               param_data,
  input  logic                                param_clear,
  output logic [NUM_LINKS*LINK_BIT_WIDTH-1:0] weight_bus,
  output logic [NUM_LINKS*2-1:0]              boundary_bus,
  output logic                                frame_loaded,
  output logic [COUNT_WIDTH-1:0]              load_count,
  output logic                                weight_clamped,
`ifdef LOADER_PARITY_EN
  output logic                                parity_error,
`endif
  output logic                                frame_incomplete
);

  localparam logic [IN_WEIGHT_WIDTH-1:0] MAX_W_IN  = IN_WEIGHT_WIDTH'(MAX_WEIGHT);
  localparam logic [LINK_BIT_WIDTH-1:0]  MAX_W_OUT = LINK_BIT_WIDTH'(MAX_WEIGHT);
  localparam logic [COUNT_WIDTH-1:0]     LAST_IDX  = COUNT_WIDTH'(NUM_LINKS - 1);
  localparam logic [COUNT_WIDTH-1:0]     FULL_CNT  = COUNT_WIDTH'(NUM_LINKS);

  loader_state_t state;

  // Field decode
  logic [IN_WEIGHT_WIDTH-1:0] in_weight;
  logic [1:0]                 in_bc;
  logic                       word_ok;
  logic                       over_max;
  logic [LINK_BIT_WIDTH-1:0]  wt_store;

  assign in_weight = param_data[IN_WEIGHT_WIDTH+1:2];
  assign in_bc     = param_data[1:0];
  assign over_max  = in_weight > MAX_W_IN;
  assign wt_store  = over_max ? MAX_W_OUT : in_weight[LINK_BIT_WIDTH-1:0];

`ifdef LOADER_PARITY_EN
  // Even parity across the whole word, parity bit included.
  assign word_ok = ~^param_data;
`else
  assign word_ok = 1'b1;
`endif

  // Handshake. A consumed word only lands in the frame if its parity holds.
  logic accept, load, commit;

  assign param_ready = (state != LD_FULL) && !param_clear;
  assign accept      = param_valid && param_ready;
  assign load        = accept && word_ok;
  assign commit      = load && (load_count == LAST_IDX);

  // Staging and committed frames, one packed slot per link.
  logic [NUM_LINKS-1:0][LINK_BIT_WIDTH-1:0] stage_w, stage_w_nxt, out_w;
  logic [NUM_LINKS-1:0][1:0]                stage_bc, stage_bc_nxt, out_bc;

  // The next-staging view lets the commit edge capture the final word
  // together with the previously staged ones.
  for (genvar k = 0; k < NUM_LINKS; k++) begin : g_slot
    logic hit;
    assign hit             = load && (load_count == COUNT_WIDTH'(k));
    assign stage_w_nxt[k]  = hit ? wt_store : stage_w[k];
    assign stage_bc_nxt[k] = hit ? in_bc    : stage_bc[k];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_w  <= '0;
      stage_bc <= '0;
    end else begin
      stage_w  <= stage_w_nxt;
      stage_bc <= stage_bc_nxt;
    end
  end

  // Committed buses survive clears; only a new commit replaces them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_w  <= '0;
      out_bc <= '0;
    end else if (commit) begin
      out_w  <= stage_w_nxt;
      out_bc <= stage_bc_nxt;
    end
  end

  assign weight_bus   = out_w;
  assign boundary_bus = out_bc;

  // Control FSM, counter and sticky status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= LD_IDLE;
      load_count       <= '0;
      frame_loaded     <= 1'b0;
      weight_clamped   <= 1'b0;
      frame_incomplete <= 1'b0;
`ifdef LOADER_PARITY_EN
      parity_error     <= 1'b0;
`endif
    end else if (param_clear) begin
      state            <= LD_IDLE;
      load_count       <= '0;
      frame_loaded     <= 1'b0;
      weight_clamped   <= 1'b0;
      frame_incomplete <= 1'b0;
`ifdef LOADER_PARITY_EN
      parity_error     <= 1'b0;
`endif
    end else begin
      if ((global_stage == STAGE_PARAMETERS_LOADING) && !frame_loaded)
        frame_incomplete <= 1'b1;

      if (load) begin
        if (over_max) weight_clamped <= 1'b1;
        load_count <= (load_count == FULL_CNT) ? load_count
                                               : load_count + COUNT_WIDTH'(1);
        if (commit) begin
          state        <= LD_FULL;
          frame_loaded <= 1'b1;
        end else begin
          state <= LD_FILL;
        end
      end

`ifdef LOADER_PARITY_EN
      if (accept && !word_ok) parity_error <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_link_parameter_loader.sv
module tb_link_parameter_loader;
  import decoder_stage_pkg::*;
  import helios_link_pkg::*;

  localparam int N   = 4;
  localparam int MAXW = 2;
  localparam int IW  = 4;
  localparam int LBW = 2;
  localparam int CW  = 3;
  localparam int DW  = IW + 2 + PARITY_BITS;
  localparam logic [STAGE_WIDTH-1:0] PL = STAGE_PARAMETERS_LOADING;
  localparam logic [STAGE_WIDTH-1:0] S0 = '0;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [STAGE_WIDTH-1:0] global_stage = '0;
  logic                   param_valid = 1'b0;
  logic                   param_ready;
  logic [DW-1:0]          param_data = '0;
  logic                   param_clear = 1'b0;
  logic [N*LBW-1:0]       weight_bus;
  logic [N*2-1:0]         boundary_bus;
  logic                   frame_loaded;
  logic [CW-1:0]          load_count;
  logic                   weight_clamped;
  logic                   frame_incomplete;
`ifdef LOADER_PARITY_EN
  logic                   parity_error;
`endif

  always #5 clk = ~clk;

  link_parameter_loader #(.NUM_LINKS(N), .MAX_WEIGHT(MAXW), .IN_WEIGHT_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .global_stage(global_stage),
    .param_valid(param_valid), .param_ready(param_ready), .param_data(param_data),
    .param_clear(param_clear), .weight_bus(weight_bus), .boundary_bus(boundary_bus),
    .frame_loaded(frame_loaded), .load_count(load_count),
    .weight_clamped(weight_clamped),
`ifdef LOADER_PARITY_EN
    .parity_error(parity_error),
`endif
    .frame_incomplete(frame_incomplete)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the words of the frame being assembled, the last
  // committed frame, and the status flags.
  int qw[$];
  int qb[$];
  int cw[N];
  int cb[N];
  bit m_loaded, m_clamp, m_incomp, m_perr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int w, input int bc);
    logic [DW-1:0] d;
    d = '0;
    d[IW+1:2] = w[IW-1:0];
    d[1:0] = bc[1:0];
`ifdef LOADER_PARITY_EN
    d[DW-1] = ^d[DW-2:0];
`endif
    return d;
  endfunction

`ifdef LOADER_PARITY_EN
  function automatic logic [DW-1:0] corrupt(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    r[DW-1] = ~r[DW-1];
    return r;
  endfunction
`endif

  function automatic bit m_full();
    return qw.size() == N;
  endfunction

  function automatic logic [N*LBW-1:0] exp_wbus();
    logic [N*LBW-1:0] r;
    int v;
    for (int k = 0; k < N; k++) begin
      v = cw[k];
      r[k*LBW +: LBW] = v[LBW-1:0];
    end
    return r;
  endfunction

  function automatic logic [N*2-1:0] exp_bbus();
    logic [N*2-1:0] r;
    int v;
    for (int k = 0; k < N; k++) begin
      v = cb[k];
      r[k*2 +: 2] = v[1:0];
    end
    return r;
  endfunction

  task automatic model_reset();
    qw.delete(); qb.delete();
    for (int k = 0; k < N; k++) begin cw[k] = 0; cb[k] = 0; end
    m_loaded = 0; m_clamp = 0; m_incomp = 0; m_perr = 0;
  endtask

  task automatic model_edge(input logic v, input logic [DW-1:0] d, input logic clr,
                            input logic [STAGE_WIDTH-1:0] stg);
    int raw;
    bit good;
    if (clr) begin
      qw.delete(); qb.delete();
      m_loaded = 0; m_clamp = 0; m_incomp = 0; m_perr = 0;
      return;
    end
    if (stg == PL && !m_loaded) m_incomp = 1;
    if (v && !m_full()) begin
      good = 1;
`ifdef LOADER_PARITY_EN
      good = (^d) == 1'b0;
`endif
      if (!good) m_perr = 1;
      else begin
        raw = int'(d[IW+1:2]);
        if (raw > MAXW) begin m_clamp = 1; raw = MAXW; end
        qw.push_back(raw);
        qb.push_back(int'(d[1:0]));
        if (m_full()) begin
          for (int k = 0; k < N; k++) begin cw[k] = qw[k]; cb[k] = qb[k]; end
          m_loaded = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("load_count", load_count, qw.size());
    chk("weight_bus", weight_bus, exp_wbus());
    chk("boundary_bus", boundary_bus, exp_bbus());
    chk("frame_loaded", frame_loaded, m_loaded);
    chk("weight_clamped", weight_clamped, m_clamp);
    chk("frame_incomplete", frame_incomplete, m_incomp);
`ifdef LOADER_PARITY_EN
    chk("parity_error", parity_error, m_perr);
`endif
  endtask

  // One clock cycle: drive, check ready before the edge, then check state.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic clr,
                     input logic [STAGE_WIDTH-1:0] stg);
    param_valid = v; param_data = d; param_clear = clr; global_stage = stg;
    #1;
    chk("param_ready", param_ready, !m_full() && !clr);
    @(posedge clk);
    model_edge(v, d, clr, stg);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, S0);
  endtask

  task automatic do_reset();
    param_valid = 0; param_clear = 0; global_stage = S0;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("ready_after_reset", param_ready, 1'b1);
  endtask

  initial begin
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("ready_after_reset", param_ready, 1'b1);

    // Back-to-back full frame.
    cyc(1, mk(1, 0), 0, S0);
    cyc(1, mk(2, 1), 0, S0);
    cyc(1, mk(0, 2), 0, S0);
    chk("bus_before_commit", weight_bus, 8'h00);
    cyc(1, mk(2, 3), 0, S0);
    chk("wbus_frame", weight_bus, 8'b10_00_10_01);
    chk("bbus_frame", boundary_bus, 8'b11_10_01_00);
    chk("loaded_frame", frame_loaded, 1'b1);
    chk("ready_full", param_ready, 1'b0);

    // Words offered while FULL are refused; loading stage after commit is fine.
    cyc(1, mk(1, 1), 0, S0);
    cyc(0, '0, 0, PL);
    chk("incomplete_after_commit", frame_incomplete, 1'b0);

    // Clear, then a clear/valid collision at load_count 2.
    cyc(0, '0, 1, S0);
    cyc(1, mk(0, 1), 0, S0);
    cyc(1, mk(1, 2), 0, S0);
    cyc(1, mk(2, 2), 1, S0);
    chk("collision_count", load_count, 3'd0);
    chk("collision_wbus_held", weight_bus, 8'b10_00_10_01);
    chk("collision_loaded", frame_loaded, 1'b0);

    // Loading stage with only three of four words.
    cyc(1, mk(1, 1), 0, S0);
    cyc(1, mk(1, 2), 0, S0);
    cyc(1, mk(0, 3), 0, S0);
    cyc(0, '0, 0, PL);
    chk("incomplete_partial", frame_incomplete, 1'b1);

    // Clamp on the final word: 7 stores as MAX_WEIGHT.
    cyc(1, mk(7, 1), 0, S0);
    chk("clamp_wbus", weight_bus, 8'b10_00_01_01);
    chk("clamp_flag", weight_clamped, 1'b1);
    idle(3);
    chk("clamp_sticky", weight_clamped, 1'b1);
    cyc(0, '0, 1, S0);
    chk("clamp_cleared", weight_clamped, 1'b0);

`ifdef LOADER_PARITY_EN
    // One bad-parity word among four good ones.
    cyc(1, mk(1, 0), 0, S0);
    cyc(1, corrupt(mk(2, 1)), 0, S0);
    cyc(1, mk(2, 2), 0, S0);
    cyc(1, mk(0, 3), 0, S0);
    chk("parity_count", load_count, 3'd3);
    chk("parity_flag", parity_error, 1'b1);
    chk("parity_no_commit", frame_loaded, 1'b0);
    cyc(1, mk(1, 1), 0, S0);
    chk("parity_commit", frame_loaded, 1'b1);
    cyc(0, '0, 1, S0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic v, c;
      logic [DW-1:0] d;
      logic [STAGE_WIDTH-1:0] s;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 19) == 0);
      s = STAGE_WIDTH'($urandom_range(0, 7));
      d = mk(($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2),
             $urandom_range(0, 3));
`ifdef LOADER_PARITY_EN
      if ($urandom_range(0, 9) == 0) d = corrupt(d);
`endif
      cyc(v, d, c, s);
    end

    // Reset in the middle of a fill after a committed frame.
    cyc(0, '0, 1, S0);
    for (int k = 0; k < N; k++) cyc(1, mk(1, 2), 0, S0);
    cyc(1, mk(2, 1), 0, S0);
    cyc(1, mk(0, 3), 0, S0);
    chk("pre_reset_count", load_count, 3'd4);
    cyc(0, '0, 1, S0);
    cyc(1, mk(2, 1), 0, S0);
    cyc(1, mk(2, 1), 0, S0);
    cyc(1, mk(2, 1), 0, S0);
    do_reset();
    chk("reset_count", load_count, 3'd0);
    chk("reset_wbus", weight_bus, 8'h00);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
